// File: rtl/crypto_io_pkg.sv
// rtl/crypto_io_pkg.sv - shared state encoding and default field sizes for the crypto byte interface
package crypto_io_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SALT_IN,
        ST_PW_IN,
        ST_KEY_WAIT,
        ST_MSG_WAIT_HOST,
        ST_MSG_IN,
        ST_MSG_HS,
        ST_RES_WAIT,
        ST_OUT_CIPH,
        ST_OUT_GAP,
        ST_OUT_MAC
    } state_t;

    localparam int DEF_SALT_BYTES   = 16;
    localparam int DEF_PW_MAX_BYTES = 32;
    localparam int DEF_MSG_BYTES    = 16;
    localparam int DEF_CIPH_BYTES   = 16;
    localparam int DEF_MAC_BYTES    = 32;

    localparam int DEF_SALT_CW = $clog2(DEF_SALT_BYTES + 1);
    localparam int DEF_PW_CW   = $clog2(DEF_PW_MAX_BYTES + 1);
    localparam int DEF_MSG_CW  = $clog2(DEF_MSG_BYTES + 1);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/word_shift_in.sv
// rtl/word_shift_in.sv - MSB-first word collector with fill count; stops accepting once DEPTH words are held
module word_shift_in
    import crypto_io_pkg::*;
#(
    parameter int DEPTH = DEF_SALT_BYTES,
    parameter int DW    = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                shift,
    input  logic [DW-1:0]       din,
    output logic [DEPTH*DW-1:0] data,
    output logic [CW-1:0]       count
);

    logic [DEPTH*DW-1:0] base_data;
    logic [DEPTH*DW-1:0] next_data;
    logic [CW-1:0]       base_count;
    logic [CW-1:0]       next_count;

    // Words land at fixed slots from the top so a short fill leaves the LSB end zero.
    always_comb begin
        base_data  = clr ? '0 : data;
        base_count = clr ? '0 : count;
        next_data  = base_data;
        next_count = base_count;
        if (shift && (base_count < CW'(DEPTH))) begin
            next_data[(DEPTH - 1 - int'(base_count)) * DW +: DW] = din;
            next_count = base_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
        end else begin
            data  <= next_data;
            count <= next_count;
        end
    end

endmodule

// File: rtl/crypto_byte_io.sv
// rtl/crypto_byte_io.sv - byte-serial host framing for the crypto core: key/message collection and result serialisation
module crypto_byte_io
    import crypto_io_pkg::*;
#(
    parameter int DW           = 8,
    parameter int SALT_BYTES   = DEF_SALT_BYTES,
    parameter int PW_MAX_BYTES = DEF_PW_MAX_BYTES,
    parameter int MSG_BYTES    = DEF_MSG_BYTES,
    parameter int CIPH_BYTES   = DEF_CIPH_BYTES,
    parameter int MAC_BYTES    = DEF_MAC_BYTES,
    parameter int MODE_W       = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DW-1:0]                      i_data,
    input  logic                               i_start,
    input  logic [MODE_W-1:0]                  i_mode,
    output logic                               o_ien,
    output logic [DW-1:0]                      o_data,
    output logic                               o_valid,
    output logic                               o_err,
    output logic [SALT_BYTES*DW-1:0]           key_salt,
    output logic [PW_MAX_BYTES*DW-1:0]         key_pw,
    output logic [$clog2(PW_MAX_BYTES+1)-1:0]  key_pw_len,
    output logic [MODE_W-1:0]                  key_mode,
    output logic                               key_valid,
    input  logic                               key_ready,
    output logic [MSG_BYTES*DW-1:0]            msg_data,
    output logic                               msg_valid,
    input  logic                               msg_ready,
    input  logic [CIPH_BYTES*DW-1:0]           res_cipher,
    input  logic [MAC_BYTES*DW-1:0]            res_mac,
    input  logic                               res_valid,
    output logic                               res_ready
);

    localparam int SALT_CW = $clog2(SALT_BYTES + 1);
    localparam int MSG_CW  = $clog2(MSG_BYTES + 1);
    localparam int OUT_CW  = $clog2(max_int(CIPH_BYTES, MAC_BYTES) + 1);

    state_t                  state;
    logic [SALT_CW-1:0]      salt_cnt;
    logic [MSG_CW-1:0]       msg_cnt;
    logic [OUT_CW-1:0]       out_idx;
    logic [CIPH_BYTES*DW-1:0] cipher_q;
    logic [MAC_BYTES*DW-1:0]  mac_q;

    logic frame_start;
    logic salt_shift;
    logic pw_shift;
    logic msg_shift;

    assign frame_start = (state == ST_IDLE) && i_start;
    assign salt_shift  = i_start && ((state == ST_IDLE) || (state == ST_SALT_IN));
    assign pw_shift    = i_start && (state == ST_PW_IN);
    assign msg_shift   = i_start && ((state == ST_MSG_WAIT_HOST) || (state == ST_MSG_IN));

    word_shift_in #(.DEPTH(SALT_BYTES), .DW(DW)) u_salt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .shift (salt_shift),
        .din   (i_data),
        .data  (key_salt),
        .count (salt_cnt)
    );

    word_shift_in #(.DEPTH(PW_MAX_BYTES), .DW(DW)) u_pw (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .shift (pw_shift),
        .din   (i_data),
        .data  (key_pw),
        .count (key_pw_len)
    );

    word_shift_in #(.DEPTH(MSG_BYTES), .DW(DW)) u_msg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .shift (msg_shift),
        .din   (i_data),
        .data  (msg_data),
        .count (msg_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            o_ien     <= 1'b0;
            o_err     <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            key_mode  <= '0;
            key_valid <= 1'b0;
            msg_valid <= 1'b0;
            res_ready <= 1'b0;
            cipher_q  <= '0;
            mac_q     <= '0;
            out_idx   <= '0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        key_mode <= i_mode;
                        o_ien    <= 1'b1;
                        state    <= (SALT_BYTES == 1) ? ST_PW_IN : ST_SALT_IN;
                    end
                end
                ST_SALT_IN: begin
                    if (!i_start) begin
                        o_err <= 1'b1;
                        o_ien <= 1'b0;
                        state <= ST_IDLE;
                    end else if (salt_cnt == SALT_CW'(SALT_BYTES - 1)) begin
                        state <= ST_PW_IN;
                    end
                end
                ST_PW_IN: begin
                    if (!i_start) begin
                        key_valid <= 1'b1;
                        state     <= ST_KEY_WAIT;
                    end
                end
                ST_KEY_WAIT: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        o_ien     <= 1'b0;
                        state     <= ST_MSG_WAIT_HOST;
                    end
                end
                ST_MSG_WAIT_HOST: begin
                    if (i_start) begin
                        if (MSG_BYTES == 1) begin
                            msg_valid <= 1'b1;
                            state     <= ST_MSG_HS;
                        end else begin
                            state <= ST_MSG_IN;
                        end
                    end
                end
                ST_MSG_IN: begin
                    if (!i_start) begin
                        o_err <= 1'b1;
                        state <= ST_IDLE;
                    end else if (msg_cnt == MSG_CW'(MSG_BYTES - 1)) begin
                        msg_valid <= 1'b1;
                        state     <= ST_MSG_HS;
                    end
                end
                ST_MSG_HS: begin
                    if (msg_ready) begin
                        msg_valid <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= ST_RES_WAIT;
                    end
                end
                ST_RES_WAIT: begin
                    if (res_valid) begin
                        cipher_q  <= res_cipher;
                        mac_q     <= res_mac;
                        res_ready <= 1'b0;
                        o_valid   <= 1'b1;
                        o_data    <= res_cipher[DW-1:0];
                        out_idx   <= OUT_CW'(1);
                        state     <= ST_OUT_CIPH;
                    end
                end
                ST_OUT_CIPH: begin
                    if (out_idx == OUT_CW'(CIPH_BYTES)) begin
                        o_valid <= 1'b0;
                        o_data  <= '0;
                        out_idx <= '0;
                        state   <= ST_OUT_GAP;
                    end else begin
                        o_data  <= cipher_q[int'(out_idx) * DW +: DW];
                        out_idx <= out_idx + OUT_CW'(1);
                    end
                end
                // One idle beat so the host sees a fresh o_valid rising edge for the MAC.
                ST_OUT_GAP: begin
                    o_valid <= 1'b1;
                    o_data  <= mac_q[DW-1:0];
                    out_idx <= OUT_CW'(1);
                    state   <= ST_OUT_MAC;
                end
                ST_OUT_MAC: begin
                    if (out_idx == OUT_CW'(MAC_BYTES)) begin
                        o_valid <= 1'b0;
                        o_data  <= '0;
                        out_idx <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        o_data  <= mac_q[int'(out_idx) * DW +: DW];
                        out_idx <= out_idx + OUT_CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_byte_io.sv
// tb/tb_crypto_byte_io.sv - scoreboard bench for crypto_byte_io framing, handshakes and output order
module tb_crypto_byte_io;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   i_data;
    logic         i_start;
    logic [0:0]   i_mode;
    logic         o_ien;
    logic [7:0]   o_data;
    logic         o_valid;
    logic         o_err;
    logic [127:0] key_salt;
    logic [255:0] key_pw;
    logic [5:0]   key_pw_len;
    logic [0:0]   key_mode;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] msg_data;
    logic         msg_valid;
    logic         msg_ready;
    logic [127:0] res_cipher;
    logic [255:0] res_mac;
    logic         res_valid;
    logic         res_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    logic [7:0]   salt_w [16];
    logic [7:0]   pw_w [40];
    logic [7:0]   msg_w [16];
    logic [127:0] exp_salt;
    logic [255:0] exp_pw;
    logic [5:0]   exp_len;
    logic [127:0] exp_msg;
    logic [8:0]   exp_q [$];

    crypto_byte_io dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_start    (i_start),
        .i_mode     (i_mode),
        .o_ien      (o_ien),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .key_salt   (key_salt),
        .key_pw     (key_pw),
        .key_pw_len (key_pw_len),
        .key_mode   (key_mode),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .res_cipher (res_cipher),
        .res_mac    (res_mac),
        .res_valid  (res_valid),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_err === 1'b1) err_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic fill_random();
        for (int i = 0; i < 16; i++) salt_w[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) pw_w[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) msg_w[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic build_expect(input int n_pw);
        exp_salt = '0;
        exp_pw   = '0;
        exp_msg  = '0;
        for (int i = 0; i < 16; i++) begin
            exp_salt[(15 - i) * 8 +: 8] = salt_w[i];
            exp_msg[(15 - i) * 8 +: 8]  = msg_w[i];
        end
        for (int i = 0; i < n_pw && i < 32; i++) exp_pw[(31 - i) * 8 +: 8] = pw_w[i];
        exp_len = (n_pw > 32) ? 6'd32 : 6'(n_pw);
    endtask

    task automatic send_key(input int n_salt, input int n_pw, input logic mode);
        for (int i = 0; i < n_salt + n_pw; i++) begin
            @(negedge clk);
            i_start = 1'b1;
            i_mode  = mode;
            i_data  = (i < n_salt) ? salt_w[i] : pw_w[i - n_salt];
        end
        @(negedge clk);
        i_start = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic load_results(input bit counting);
        logic [7:0] w;
        for (int k = 0; k < 16; k++) begin
            w = counting ? 8'(k) : 8'($urandom_range(0, 255));
            res_cipher[k * 8 +: 8] = w;
            exp_q.push_back({1'b1, w});
        end
        exp_q.push_back(9'h000);
        for (int k = 0; k < 32; k++) begin
            w = counting ? 8'(k) : 8'($urandom_range(0, 255));
            res_mac[k * 8 +: 8] = w;
            exp_q.push_back({1'b1, w});
        end
    endtask

    task automatic key_phase(input int hold);
        int w = 0;
        while (key_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL key_valid_wait got %b want 1", key_valid);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if (key_valid !== 1'b1 || o_ien !== 1'b1 || key_salt !== exp_salt ||
                key_pw !== exp_pw || key_pw_len !== exp_len) begin
                n_bad++;
                $display("FAIL key_hold cyc %0d valid %b ien %b len %0d want 1 1 %0d", i, key_valid, o_ien, key_pw_len, exp_len);
            end
        end
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        n_cmp++;
        if ({key_valid, o_ien} !== 2'b00) begin
            n_bad++;
            $display("FAIL key_handshake valid/ien got %b want 00", {key_valid, o_ien});
        end
    endtask

    task automatic msg_phase(input int hold);
        int w = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i_start = 1'b1;
            i_data  = msg_w[i];
        end
        @(negedge clk);
        i_start = 1'b0;
        i_data  = 8'h00;
        while (msg_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (msg_valid !== 1'b1 || msg_data !== exp_msg) begin
            n_bad++;
            $display("FAIL msg_capture valid %b data %h want 1 %h", msg_valid, msg_data, exp_msg);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({msg_valid, res_ready} !== 2'b10 || msg_data !== exp_msg) begin
                n_bad++;
                $display("FAIL msg_hold cyc %0d valid/rdy %b data %h want 10 %h", i, {msg_valid, res_ready}, msg_data, exp_msg);
            end
        end
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
        n_cmp++;
        if ({msg_valid, res_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL msg_handshake valid/res_ready got %b want 01", {msg_valid, res_ready});
        end
    endtask

    task automatic result_phase(input int abort_at);
        int w = 0;
        int idx = 0;
        logic [8:0] e;
        while (res_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (res_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL res_ready_wait got %b want 1", res_ready);
        end
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({o_valid, o_data} !== e) begin
                n_bad++;
                $display("FAIL out_word %0d valid/data got %b/%h want %b/%h", idx, o_valid, o_data, e[8], e[7:0]);
            end
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({o_valid, o_data} !== 9'h000) begin
                    n_bad++;
                    $display("FAIL abort_reset valid/data got %b/%h want 0/00", o_valid, o_data);
                end
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            idx++;
            @(negedge clk);
        end
        n_cmp++;
        if ({o_valid, o_data, res_ready, o_ien} !== 11'h000) begin
            n_bad++;
            $display("FAIL frame_end_idle valid %b data %h rdy %b ien %b want all 0", o_valid, o_data, res_ready, o_ien);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({o_valid, o_ien, o_err, key_valid, msg_valid, res_ready} !== 6'b0 || o_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b data %h want 000000 00", {o_valid, o_ien, o_err, key_valid, msg_valid, res_ready}, o_data);
        end
        n_cmp++;
        if (key_salt !== '0 || key_pw !== '0 || key_pw_len !== 6'd0 || msg_data !== '0 || key_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data len %0d mode %b want 0 0", key_pw_len, key_mode);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_valid, o_ien, key_valid, msg_valid, res_ready} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_release got %b want 00000", {o_valid, o_ien, key_valid, msg_valid, res_ready});
        end
    endtask

    task automatic test_nominal();
        int base = err_cnt;
        for (int i = 0; i < 16; i++) salt_w[i] = 8'(i);
        for (int i = 0; i < 15; i++) pw_w[i] = 8'(8'h41 + i);
        for (int i = 0; i < 16; i++) msg_w[i] = 8'(8'hF0 + i);
        build_expect(15);
        send_key(16, 15, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (key_salt !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_bad++;
            $display("FAIL nominal_salt got %h want 000102030405060708090a0b0c0d0e0f", key_salt);
        end
        n_cmp++;
        if (key_pw_len !== 6'd15 || key_pw[7:0] !== 8'h00 || key_pw !== exp_pw) begin
            n_bad++;
            $display("FAIL nominal_pw len %0d pw %h want 15 %h", key_pw_len, key_pw, exp_pw);
        end
        n_cmp++;
        if ({key_valid, o_ien, key_mode} !== 3'b110) begin
            n_bad++;
            $display("FAIL nominal_key_ctrl got %b want 110", {key_valid, o_ien, key_mode});
        end
        key_phase(0);
        msg_phase(0);
        n_cmp++;
        if (msg_data !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff) begin
            n_bad++;
            $display("FAIL nominal_msg got %h want f0f1...ff", msg_data);
        end
        load_results(1'b1);
        result_phase(-1);
        n_cmp++;
        if (err_cnt !== base) begin
            n_bad++;
            $display("FAIL nominal_err got %0d pulses want 0", err_cnt - base);
        end
    endtask

    task automatic test_pw_overflow();
        int base = err_cnt;
        fill_random();
        build_expect(40);
        send_key(16, 40, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (key_pw_len !== 6'd32 || key_pw !== exp_pw) begin
            n_bad++;
            $display("FAIL overflow_pw len %0d pw %h want 32 %h", key_pw_len, key_pw, exp_pw);
        end
        n_cmp++;
        if (key_salt !== exp_salt || err_cnt !== base) begin
            n_bad++;
            $display("FAIL overflow_salt_err salt %h err %0d want %h 0", key_salt, err_cnt - base, exp_salt);
        end
        key_phase(0);
        msg_phase(0);
        load_results(1'b0);
        result_phase(-1);
    endtask

    task automatic test_short_salt();
        int base = err_cnt;
        fill_random();
        send_key(10, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (key_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL short_salt_key_valid cyc %0d got %b want 0", i, key_valid);
            end
        end
        n_cmp++;
        if (err_cnt - base !== 1 || o_ien !== 1'b0) begin
            n_bad++;
            $display("FAIL short_salt_err pulses %0d ien %b want 1 0", err_cnt - base, o_ien);
        end
    endtask

    task automatic test_backpressure_mode();
        fill_random();
        build_expect(8);
        send_key(16, 8, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (key_mode !== 1'b1) begin
            n_bad++;
            $display("FAIL mode_latch got %b want 1", key_mode);
        end
        key_phase(5);
        msg_phase(3);
        load_results(1'b0);
        result_phase(-1);
    endtask

    task automatic test_reset_in_mac();
        fill_random();
        build_expect(12);
        send_key(16, 12, 1'b0);
        key_phase(0);
        msg_phase(0);
        load_results(1'b0);
        result_phase(24);
        n_cmp++;
        if ({o_valid, o_ien, key_valid, res_ready} !== 4'b0 || key_pw_len !== 6'd0) begin
            n_bad++;
            $display("FAIL post_abort_idle ctrl %b len %0d want 0000 0", {o_valid, o_ien, key_valid, res_ready}, key_pw_len);
        end
        fill_random();
        build_expect(20);
        send_key(16, 20, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (key_salt !== exp_salt || key_pw !== exp_pw || key_pw_len !== exp_len) begin
            n_bad++;
            $display("FAIL post_abort_key len %0d want %0d", key_pw_len, exp_len);
        end
        key_phase(0);
        msg_phase(0);
        load_results(1'b0);
        result_phase(-1);
    endtask

    initial begin
        i_data     = 8'h00;
        i_start    = 1'b0;
        i_mode     = 1'b0;
        key_ready  = 1'b0;
        msg_ready  = 1'b0;
        res_valid  = 1'b0;
        res_cipher = '0;
        res_mac    = '0;
        test_reset();
        test_nominal();
        test_pw_overflow();
        test_short_salt();
        test_backpressure_mode();
        test_reset_in_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crypto_byte_io.md
Name: crypto_byte_io

Overview:
- Parametrised byte-serial host interface for the AES/SHA3 crypto core.
- Collects salt, a variable-length password and the message from a narrow `i_data` stream gated by `i_start`.
- Presents them to the core over valid/ready handshakes.
- Serialises the returned cipher block, then the HMAC value, back onto `o_data` with `o_valid`.
- Generalises the fixed 16/15/16-byte in, 16/32-byte out framing to configurable field sizes, data width and mode width, with length reporting and error signalling.

Parameters:
- DW, 8: host data width in bits.
- SALT_BYTES, 16: salt field length in DW-words.
- PW_MAX_BYTES, 32: maximum password length in words; the actual length is set by `i_start` duration.
- MSG_BYTES, 16: message field length in words.
- CIPH_BYTES, 16: cipher output length in words.
- MAC_BYTES, 32: MAC output length in words.
- MODE_W, 1: width of the mode select.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_data  in  DW  host input word.
- i_start  in  1  host word-valid for the current input phase.
- i_mode  in  MODE_W  operation mode, sampled on the first salt word.
- o_ien  out  1  key phase busy; its falling edge tells the host to send the message.
- o_data  out  DW  host output word.
- o_valid  out  1  `o_data` holds a valid output word.
- o_err  out  1  one-cycle pulse on a framing error.
- key_salt  out  SALT_BYTES*DW  salt, first word in the MSBs.
- key_pw  out  PW_MAX_BYTES*DW  password, first word in the MSBs, zero-padded at the LSB end.
- key_pw_len  out  $clog2(PW_MAX_BYTES+1)  number of password words received.
- key_mode  out  MODE_W  latched `i_mode`.
- key_valid  out  1  key material valid.
- key_ready  in  1  core accepts the key material.
- msg_data  out  MSG_BYTES*DW  message, first word in the MSBs.
- msg_valid  out  1  message valid.
- msg_ready  in  1  core accepts the message.
- res_cipher  in  CIPH_BYTES*DW  cipher result.
- res_mac  in  MAC_BYTES*DW  MAC result.
- res_valid  in  1  results valid.
- res_ready  out  1  block accepts the results (high only in RES_WAIT).

Behaviour:
- Reset clears every register, output and counter to 0 and puts the FSM in IDLE. Reset mid-operation aborts the frame; no partial output is emitted after release.
- States: IDLE, SALT_IN, PW_IN, KEY_WAIT, MSG_WAIT_HOST, MSG_IN, MSG_HS, RES_WAIT, OUT_CIPH, OUT_GAP, OUT_MAC.
- IDLE:
  - `i_start`=1 captures word 0 of the salt and latches `i_mode`.
  - Go to SALT_IN with word count 1; `o_ien`=1.
- SALT_IN:
  - Shift in one word per cycle while `i_start`=1.
  - When SALT_BYTES words are captured, go to PW_IN.
  - `i_start`=0 before that: pulse `o_err`, return to IDLE.
- PW_IN:
  - Each `i_start`=1 cycle stores one word and increments `pw_len`.
  - Words beyond PW_MAX_BYTES are discarded and `pw_len` saturates at PW_MAX_BYTES. Overflow alone is not an error.
  - First `i_start`=0 cycle: go to KEY_WAIT with `key_valid`=1.
  - Zero password words (start falls straight after the salt) is legal: `pw_len`=0 and `key_pw`=0.
- KEY_WAIT:
  - Hold `key_*` stable until `key_valid`&`key_ready`.
  - Then drop `key_valid` and `o_ien` in the same cycle and go to MSG_WAIT_HOST.
  - `o_ien` is 1 from the first salt word through the handshake cycle.
- MSG_WAIT_HOST / MSG_IN:
  - The first `i_start`=1 word is the message MSB word.
  - Collect MSG_BYTES consecutive words.
  - `i_start` dropping before the field is full: pulse `o_err`, return to IDLE.
  - Words arriving after the field is full are ignored.
- MSG_HS: `msg_valid`=1 until `msg_ready`, then go to RES_WAIT.
- RES_WAIT: `res_ready`=1; on `res_valid`, latch both results and go to OUT_CIPH.
- OUT_CIPH:
  - `o_valid`=1 for exactly CIPH_BYTES cycles.
  - Word k is `res_cipher[k*DW +: DW]`, least-significant word first.
- OUT_GAP: exactly one cycle with `o_valid`=0, so the host sees a fresh rising edge.
- OUT_MAC: `o_valid`=1 for MAC_BYTES cycles, LSW first, then return to IDLE.
- `o_data`=0 whenever `o_valid`=0.
- `i_start` in any of KEY_WAIT, MSG_HS, RES_WAIT or the OUT states is ignored and causes no error.
- Latency:
  - `key_valid` rises in the cycle after the first `i_start`=0 in PW_IN.
  - The first output word appears the cycle after the `res_valid`/`res_ready` handshake.
  - Frame end to IDLE takes CIPH_BYTES+1+MAC_BYTES cycles after that.

Decomposition:
- Package `crypto_io_pkg`:
  - FSM state enum.
  - Default field-length constants (16/32/16/16/32).
  - Derived count widths via $clog2.
- Sub-module `word_shift_in` (parametrised DEPTH, DW, MSB-first shift register with fill count and saturating stop), instantiated for salt, password and message.
- Output serialisation stays in the top FSM.

Test Plan:
- Nominal frame:
  - Stimulus: salt 0x000102…0F, 15-word password 0x41…4F, then message 0xF0…FF.
  - Required: `key_salt`=0x00…0F, `key_pw_len`=15, `key_pw` low word zero, `o_ien` falls on `key_ready`.
- Output order:
  - Stimulus: `res_cipher`=0x0F0E…00, `res_mac`=0x1F1E…00.
  - Required: `o_data` sequence 00,01,…,0F, one gap cycle with `o_valid`=0, then 00…1F; then IDLE.
- Password overflow:
  - Stimulus: 40 password words with PW_MAX_BYTES=32.
  - Required: `key_pw_len`=32, words 33-40 dropped, `o_err` stays 0.
- Short salt:
  - Stimulus: `i_start` drops after 10 words.
  - Required: one `o_err` pulse, back in IDLE, `key_valid` never asserted.
- Backpressure and mode:
  - Stimulus: `i_mode`=1, `key_ready` held low 5 cycles, `msg_ready` low 3 cycles.
  - Required: `key_*`/`msg_*` stable throughout, `key_mode`=1.
- Async reset during OUT_MAC word 7:
  - Required: `o_valid`=0 immediately; after release a full new frame passes correctly.
